// File: rtl/drive_pkg.sv
// drive_pkg: shared encodings for drive_ctrl and its manual/semi-auto/auto requesters.
package drive_pkg;
    typedef enum logic [1:0] {
        ST_OFF          = 2'b00,
        ST_NOT_STARTING = 2'b01,
        ST_STARTING     = 2'b11,
        ST_MOVING       = 2'b10
    } drive_state_t;
    typedef enum logic [1:0] {
        MODE_MAN  = 2'b00,
        MODE_SEMI = 2'b01,
        MODE_AUTO = 2'b10,
        MODE_RSVD = 2'b11
    } drive_mode_t;
    typedef enum logic [1:0] {PWR_OFF, PWR_ON, WAIT_REL, WAIT_OFF} pwr_state_t;
    localparam int MV_FWD = 3;
    localparam int MV_BWD = 2;
    localparam int MV_L   = 1;
    localparam int MV_R   = 0;
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return m == MODE_RSVD ? MODE_MAN : m;
    endfunction
endpackage

// File: rtl/hold_counter.sv
// hold_counter: saturating press/idle counter; hit flags the cycle whose count reaches limit.
module hold_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         hit
);
    logic [W-1:0] cnt;
    assign hit = inc && (cnt + 1'b1 >= limit);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && cnt < limit) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/drive_ctrl.sv
// drive_ctrl: power sequencing, requester arbitration and actuator gating for a drive.
// Define DRIVE_CTRL_IDLE_OFF_EN to power off after IDLE_CYC idle cycles in NOT_STARTING.
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int PWR_ON_CYC  = 100_000_000,
    parameter int PWR_OFF_CYC = 300_000_000,
    parameter int IDLE_CYC    = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic [1:0] mode_sel,
    input  logic [1:0] man_state_next,
    input  logic [1:0] semi_state_next,
    input  logic [1:0] auto_state_next,
    input  logic       man_stall,
    input  logic [3:0] man_move,
    input  logic [3:0] semi_move,
    input  logic [3:0] auto_move,
    output logic       power_on,
    output logic [1:0] state_cur,
    output logic [1:0] mode_cur,
    output logic [2:0] grant,
    output logic       move_fwd,
    output logic       move_bwd,
    output logic       turn_l,
    output logic       turn_r
);
    pwr_state_t st, st_nx;
    logic [1:0] state_nx, mode_nx, gnext;
    logic [3:0] gmove, mv, mv_nx;
    logic       btn_hit, btn_clr, idle_hit, stop;

    assign power_on = st == WAIT_REL || st == PWR_ON;
    assign grant    = power_on ? 3'b001 << mode_cur : 3'b000;
    assign gnext    = mode_cur == MODE_AUTO ? auto_state_next : mode_cur == MODE_SEMI ? semi_state_next : man_state_next;
    assign gmove    = mode_cur == MODE_AUTO ? auto_move : mode_cur == MODE_SEMI ? semi_move : man_move;
    assign stop     = power_on && (gnext == ST_OFF || (man_stall && mode_cur == MODE_MAN) || idle_hit);
    // Held at zero while waiting for release so one long press cannot toggle power twice.
    assign btn_clr  = !power_btn || st_nx != st || st == WAIT_REL || st == WAIT_OFF;

    hold_counter #(.W(32)) u_btn (
        .clk  (clk),
        .rst  (rst),
        .clr  (btn_clr),
        .inc  (power_btn),
        .limit(st == PWR_OFF ? 32'(PWR_ON_CYC) : 32'(PWR_OFF_CYC)),
        .hit  (btn_hit)
    );

`ifdef DRIVE_CTRL_IDLE_OFF_EN
    logic idle_inc;
    assign idle_inc = st == PWR_ON && state_cur == ST_NOT_STARTING && gnext == ST_NOT_STARTING && gmove == 4'b0000;
    hold_counter #(.W(32)) u_idle (
        .clk  (clk),
        .rst  (rst),
        .clr  (!idle_inc),
        .inc  (idle_inc),
        .limit(32'(IDLE_CYC)),
        .hit  (idle_hit)
    );
`else
    // A negative idle budget is not a valid configuration, so this is constant 0.
    assign idle_hit = IDLE_CYC < 0;
`endif

    always_comb begin
        st_nx    = st;
        state_nx = state_cur;
        mode_nx  = mode_cur;
        mv_nx    = 4'b0000;
        case (st)
            PWR_OFF: if (btn_hit) begin
                st_nx    = WAIT_REL;
                state_nx = ST_NOT_STARTING;
                mode_nx  = map_mode(mode_sel);
            end
            WAIT_OFF: if (!power_btn) st_nx = PWR_OFF;
            default: if ((st == PWR_ON && btn_hit) || stop) begin
                st_nx    = WAIT_OFF;
                state_nx = ST_OFF;
            end else begin
                if (st == WAIT_REL && !power_btn) st_nx = PWR_ON;
                state_nx = gnext;
                if (state_cur == ST_NOT_STARTING && mode_sel != MODE_RSVD) mode_nx = mode_sel;
                mv_nx = mode_nx != mode_cur ? 4'b0000 :
                        {gmove[MV_FWD], gmove[MV_BWD], gmove[MV_L] & ~gmove[MV_R], gmove[MV_R] & ~gmove[MV_L]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= PWR_OFF;
            state_cur <= ST_OFF;
            mode_cur  <= MODE_MAN;
            mv        <= 4'b0000;
        end else begin
            st        <= st_nx;
            state_cur <= state_nx;
            mode_cur  <= mode_nx;
            mv        <= mv_nx;
        end
    end

    assign move_fwd = mv[MV_FWD] && state_cur == ST_MOVING;
    assign move_bwd = mv[MV_BWD] && state_cur == ST_MOVING;
    assign turn_l   = mv[MV_L];
    assign turn_r   = mv[MV_R];
endmodule

// File: tb/tb_drive_ctrl.sv
// tb_drive_ctrl: directed and randomized checks of drive_ctrl against a behavioural model.
module tb_drive_ctrl;
    localparam int ON_CYC = 4;
    localparam int OFF_CYC = 8;
    localparam int IDLE_CYC = 16;

    logic clk = 1'b0;
    logic rst, power_btn, man_stall;
    logic [1:0] mode_sel, man_state_next, semi_state_next, auto_state_next;
    logic [3:0] man_move, semi_move, auto_move;
    logic power_on, move_fwd, move_bwd, turn_l, turn_r;
    logic [1:0] state_cur, mode_cur;
    logic [2:0] grant;
    logic [11:0] obs;

    int errors = 0;
    int checks = 0;

    bit m_on, m_latch;
    int m_press, m_idle;
    logic [1:0] m_st, m_md;
    logic [3:0] m_mv;

    always #5 clk = ~clk;

    drive_ctrl #(.PWR_ON_CYC(ON_CYC), .PWR_OFF_CYC(OFF_CYC), .IDLE_CYC(IDLE_CYC)) dut (
        .clk(clk), .rst(rst), .power_btn(power_btn), .mode_sel(mode_sel),
        .man_state_next(man_state_next), .semi_state_next(semi_state_next), .auto_state_next(auto_state_next),
        .man_stall(man_stall), .man_move(man_move), .semi_move(semi_move), .auto_move(auto_move),
        .power_on(power_on), .state_cur(state_cur), .mode_cur(mode_cur), .grant(grant),
        .move_fwd(move_fwd), .move_bwd(move_bwd), .turn_l(turn_l), .turn_r(turn_r)
    );

    assign obs = {power_on, state_cur, mode_cur, grant, move_fwd, move_bwd, turn_l, turn_r};

    function automatic logic [11:0] expected();
        logic [2:0] g;
        g = m_on ? 3'(1 << m_md) : 3'b000;
        return {m_on, m_st, m_md, g, m_mv[3] && m_st == 2'b10, m_mv[2] && m_st == 2'b10, m_mv[1], m_mv[0]};
    endfunction

    task automatic model_step();
        logic [1:0] gn, newmd;
        logic [3:0] gm;
        bit idle_cond, idle_hit;
        if (rst) begin
            m_on = 0; m_latch = 0; m_press = 0; m_idle = 0; m_st = 0; m_md = 0; m_mv = 0;
        end else if (!m_on) begin
            m_idle = 0;
            if (m_latch) begin
                if (!power_btn) m_latch = 0;
                m_press = 0;
            end else begin
                m_press = power_btn ? m_press + 1 : 0;
                if (m_press >= ON_CYC) begin
                    m_on = 1; m_latch = 1; m_press = 0; m_st = 2'b01; m_mv = 0;
                    m_md = mode_sel == 2'b11 ? 2'b00 : mode_sel;
                end
            end
        end else begin
            gn = m_md == 0 ? man_state_next : m_md == 1 ? semi_state_next : auto_state_next;
            gm = m_md == 0 ? man_move : m_md == 1 ? semi_move : auto_move;
            idle_cond = !m_latch && m_st == 2'b01 && gm == 0 && gn == 2'b01;
`ifdef DRIVE_CTRL_IDLE_OFF_EN
            idle_hit = idle_cond && m_idle + 1 >= IDLE_CYC;
`else
            idle_hit = 0;
`endif
            m_idle = idle_cond ? m_idle + 1 : 0;
            m_press = (!m_latch && power_btn) ? m_press + 1 : 0;
            if (m_press >= OFF_CYC || gn == 2'b00 || (man_stall && m_md == 0) || idle_hit) begin
                m_on = 0; m_latch = 1; m_st = 0; m_mv = 0; m_press = 0; m_idle = 0;
            end else begin
                if (m_latch && !power_btn) m_latch = 0;
                newmd = (m_st == 2'b01 && mode_sel != 2'b11) ? mode_sel : m_md;
                m_mv = newmd != m_md ? 4'b0 : {gm[3], gm[2], gm[1] && !gm[0], gm[0] && !gm[1]};
                m_st = gn;
                m_md = newmd;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        power_btn = 0; man_stall = 0; mode_sel = 2'b00;
        man_state_next = 2'b01; semi_state_next = 2'b01; auto_state_next = 2'b01;
        man_move = 0; semi_move = 0; auto_move = 0;
    endtask

    task automatic power_up(input logic [1:0] m);
        power_btn = 0;
        tick();
        power_btn = 1;
        mode_sel = m;
        repeat (ON_CYC) tick();
        power_btn = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        set_quiet();
        repeat (2) tick();
        rst = 0;
        checks++;
        if (obs !== 12'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 12'b0);
        end
    endtask

    task automatic test_power_on();
        int drops = 0;
        mode_sel = 2'b01;
        tick();
        power_btn = 1;
        repeat (ON_CYC - 1) tick();
        checks++;
        if (power_on !== 1'b0) begin
            errors++; $display("FAIL power_on_early: got %b expected 0", power_on);
        end
        tick();
        checks++;
        if ({power_on, state_cur, grant} !== 6'b1_01_010) begin
            errors++; $display("FAIL power_on_entry: got %b expected %b", {power_on, state_cur, grant}, 6'b1_01_010);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (power_on !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++; $display("FAIL power_on_long_hold: got %0d off cycles expected 0", drops);
        end
        power_btn = 0;
        tick();
        checks++;
        if (obs !== expected() || power_on !== 1'b1) begin
            errors++; $display("FAIL power_on_release: got %b expected %b", obs, expected());
        end
    endtask

    task automatic test_manual_move();
        mode_sel = 2'b00;
        tick();
        checks++;
        if ({mode_cur, grant} !== 5'b00_001) begin
            errors++; $display("FAIL manual_grant: got %b expected %b", {mode_cur, grant}, 5'b00_001);
        end
        man_state_next = 2'b10; man_move = 4'b1000;
        tick();
        checks++;
        if ({state_cur, move_fwd, move_bwd, turn_l, turn_r} !== 6'b10_1000) begin
            errors++; $display("FAIL manual_fwd: got %b expected %b", {state_cur, move_fwd, move_bwd, turn_l, turn_r}, 6'b10_1000);
        end
        man_move = 4'b0111;
        tick();
        checks++;
        if ({state_cur, move_fwd, move_bwd, turn_l, turn_r} !== 6'b10_0100) begin
            errors++; $display("FAIL manual_turn_conflict: got %b expected %b", {state_cur, move_fwd, move_bwd, turn_l, turn_r}, 6'b10_0100);
        end
        man_state_next = 2'b11; man_move = 4'b1010;
        tick();
        checks++;
        if ({state_cur, move_fwd, move_bwd, turn_l, turn_r} !== 6'b11_0010) begin
            errors++; $display("FAIL manual_fwd_gated: got %b expected %b", {state_cur, move_fwd, move_bwd, turn_l, turn_r}, 6'b11_0010);
        end
        man_stall = 1;
        tick();
        man_stall = 0;
        checks++;
        if (obs !== 12'b0) begin
            errors++; $display("FAIL manual_stall_off: got %b expected %b", obs, 12'b0);
        end
        set_quiet();
    endtask

    task automatic test_mode_change();
        power_up(2'b00);
        man_state_next = 2'b11;
        tick();
        mode_sel = 2'b10;
        repeat (2) tick();
        checks++;
        if ({state_cur, mode_cur, grant} !== 7'b11_00_001) begin
            errors++; $display("FAIL mode_held_starting: got %b expected %b", {state_cur, mode_cur, grant}, 7'b11_00_001);
        end
        man_state_next = 2'b01;
        tick();
        checks++;
        if ({state_cur, mode_cur} !== 4'b01_00) begin
            errors++; $display("FAIL mode_held_return: got %b expected %b", {state_cur, mode_cur}, 4'b01_00);
        end
        tick();
        checks++;
        if ({state_cur, mode_cur, grant} !== 7'b01_10_100) begin
            errors++; $display("FAIL mode_switch_auto: got %b expected %b", {state_cur, mode_cur, grant}, 7'b01_10_100);
        end
    endtask

    task automatic test_hold_wins();
        power_btn = 1;
        repeat (OFF_CYC - 1) tick();
        checks++;
        if (power_on !== 1'b1) begin
            errors++; $display("FAIL hold_short: got %b expected 1", power_on);
        end
        auto_state_next = 2'b10;
        tick();
        checks++;
        if ({power_on, state_cur, grant} !== 6'b0) begin
            errors++; $display("FAIL hold_wins: got %b expected %b", {power_on, state_cur, grant}, 6'b0);
        end
        set_quiet();
        tick();
    endtask

    task automatic test_reset_mid();
        power_up(2'b00);
        man_state_next = 2'b10; man_move = 4'b1001;
        tick();
        checks++;
        if ({power_on, state_cur, move_fwd, turn_r} !== 5'b1_10_1_1) begin
            errors++; $display("FAIL reset_mid_moving: got %b expected %b", {power_on, state_cur, move_fwd, turn_r}, 5'b1_10_1_1);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (obs !== 12'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b expected %b", obs, 12'b0);
        end
        set_quiet();
    endtask

    task automatic test_idle();
        logic exp_on;
`ifdef DRIVE_CTRL_IDLE_OFF_EN
        exp_on = 1'b0;
`else
        exp_on = 1'b1;
`endif
        power_up(2'b01);
        repeat (IDLE_CYC + 4) tick();
        checks++;
        if (power_on !== exp_on) begin
            errors++; $display("FAIL idle_off: got %b expected %b", power_on, exp_on);
        end
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 800; i++) begin
            if (burst == 0 && $urandom_range(0, 25) == 0) burst = $urandom_range(1, 12);
            power_btn = burst > 0;
            if (burst > 0) burst--;
            rst = $urandom_range(0, 299) == 0;
            man_stall = $urandom_range(0, 59) == 0;
            if ($urandom_range(0, 7) == 0) mode_sel = 2'($urandom);
            man_state_next = $urandom_range(0, 39) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
            semi_state_next = $urandom_range(0, 39) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
            auto_state_next = $urandom_range(0, 39) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
            man_move = 4'($urandom); semi_move = 4'($urandom); auto_move = 4'($urandom);
            tick();
            checks++;
            if (obs !== expected()) begin
                errors++; $display("FAIL random_cycle_%0d: got %b expected %b", i, obs, expected());
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        set_quiet();
        test_reset();
        test_power_on();
        test_manual_move();
        test_mode_change();
        test_hold_wins();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
